// File: rtl/tm1638_keys_if.sv
// Scan-frame input and key-event handshake between the TM1638 spi reader,
// the key-scan block and the application logic.
interface tm1638_keys_if;
    logic        i_Data_Valid;
    logic [63:0] i_Data;
    logic [7:0]  o_Keys;
    logic        o_Event_Valid;
    logic        i_Event_Ready;
    logic [2:0]  o_Event_Key;
    logic        o_Event_Press;
    logic        o_Overflow;

    modport master (
        output i_Data_Valid, i_Data, i_Event_Ready,
        input  o_Keys, o_Event_Valid, o_Event_Key, o_Event_Press, o_Overflow
    );

    modport slave (
        input  i_Data_Valid, i_Data, i_Event_Ready,
        output o_Keys, o_Event_Valid, o_Event_Key, o_Event_Press, o_Overflow
    );
endinterface

// File: rtl/tm1638_keys.sv
// TM1638 key-scan consumer: maps 8 keys from a scan frame, debounces them and
// queues press/release events in a first-word-fall-through FIFO.
module tm1638_keys #(
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input logic           i_Clk,
    input logic           i_Rst_n,
    tm1638_keys_if.slave  bus
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEB = 5'(DEBOUNCE_SCANS);

    logic [7:0]    mapped;
    logic [7:0]    raw;
    logic          scan;
    logic [7:0]    keys;
    logic [7:0]    keys_next;
    logic [3:0]    cnt      [8];
    logic [3:0]    cnt_next [8];
    logic [7:0]    change;
    logic [7:0]    pend;
    logic [7:0]    dir;
    logic [7:0]    clr;
    logic [2:0]    sel;
    logic          found;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [3:0]    head;

    // Key b sits at bit 0 of byte b, key b+4 at bit 4 of byte b
    always_comb begin
        mapped = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            mapped[b]     = bus.i_Data[8*b];
            mapped[b + 4] = bus.i_Data[8*b + 4];
        end
    end

    always_comb begin
        keys_next = keys;
        change    = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            cnt_next[k] = cnt[k];
            if (scan) begin
                if (raw[k] == keys[k]) begin
                    cnt_next[k] = '0;
                end else if (({1'b0, cnt[k]} + 5'd1) == DEB) begin
                    keys_next[k] = raw[k];
                    cnt_next[k]  = '0;
                    change[k]    = 1'b1;
                end else begin
                    cnt_next[k] = cnt[k] + 4'd1;
                end
            end
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && bus.i_Event_Ready;

    // Lowest pending key drains first; fullness is judged before this cycle's pop
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (pend[k] && !found) begin
                sel   = 3'(k);
                found = 1'b1;
            end
        end
        push = found && !full;
        clr  = push ? (8'b1 << sel) : '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            raw      <= '0;
            scan     <= 1'b0;
            keys     <= '0;
            pend     <= '0;
            dir      <= '0;
            overflow <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            for (int unsigned k = 0; k < 8; k++) cnt[k] <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            scan <= bus.i_Data_Valid;
            if (bus.i_Data_Valid) raw <= mapped;
            keys <= keys_next;
            for (int unsigned k = 0; k < 8; k++) begin
                cnt[k] <= cnt_next[k];
                if (change[k]) dir[k] <= keys_next[k];
            end
            // A new change re-arms a key even if it is being drained this cycle
            pend <= (pend & ~clr) | change;
            if (|(change & pend)) overflow <= 1'b1;
            if (push) begin
                mem[wptr[AW-1:0]] <= {sel, dir[sel]};
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    assign head              = mem[rptr[AW-1:0]];
    assign bus.o_Keys        = keys;
    assign bus.o_Event_Valid = !empty;
    assign bus.o_Event_Key   = empty ? 3'b000 : head[3:1];
    assign bus.o_Event_Press = empty ? 1'b0 : head[0];
    assign bus.o_Overflow    = overflow;
endmodule

// File: tb/tb_tm1638_keys.sv
// Directed bench for tm1638_keys: expected events are queued at stimulus time
// and popped by per-DUT monitors whenever an event handshake occurs.
module tb_tm1638_keys;
    typedef struct packed {
        logic [2:0] key;
        logic       press;
    } ev_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    ev_t  qa[$];
    ev_t  qb[$];
    ev_t  ea;
    ev_t  eb;

    tm1638_keys_if ia ();
    tm1638_keys_if ib ();

    tm1638_keys #(.DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)) dut_a (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (ia)
    );

    tm1638_keys #(.DEBOUNCE_SCANS(1), .FIFO_DEPTH(4)) dut_b (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [2:0] k, input logic p);
        ev_t e;
        e.key = k; e.press = p;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [2:0] k, input logic p);
        ev_t e;
        e.key = k; e.press = p;
        qb.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle strobe, then idle so consecutive scans are 10 cycles apart
    task automatic scan(input bit on_b, input logic [63:0] d);
        @(posedge clk); #1;
        if (on_b) begin
            ib.i_Data = d; ib.i_Data_Valid = 1'b1;
        end else begin
            ia.i_Data = d; ia.i_Data_Valid = 1'b1;
        end
        @(posedge clk); #1;
        ia.i_Data_Valid = 1'b0;
        ib.i_Data_Valid = 1'b0;
        wait_cycles(8);
    endtask

    always @(negedge clk) begin
        if (rst_n && ia.o_Event_Valid && ia.i_Event_Ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_event: got key %0d press %0d, expected no event",
                         ia.o_Event_Key, ia.o_Event_Press);
            end else begin
                ea = qa.pop_front();
                chk("a_event_key", 64'(ia.o_Event_Key), 64'(ea.key));
                chk("a_event_press", 64'(ia.o_Event_Press), 64'(ea.press));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ib.o_Event_Valid && ib.i_Event_Ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_event: got key %0d press %0d, expected no event",
                         ib.o_Event_Key, ib.o_Event_Press);
            end else begin
                eb = qb.pop_front();
                chk("b_event_key", 64'(ib.o_Event_Key), 64'(eb.key));
                chk("b_event_press", 64'(ib.o_Event_Press), 64'(eb.press));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ia.i_Data_Valid = 1'b0; ia.i_Data = '0; ia.i_Event_Ready = 1'b0;
        ib.i_Data_Valid = 1'b0; ib.i_Data = '0; ib.i_Event_Ready = 1'b0;
        wait_cycles(3);
        chk("reset_keys", 64'(ia.o_Keys), 64'h0);
        chk("reset_valid", 64'(ia.o_Event_Valid), 64'h0);
        chk("reset_overflow", 64'(ia.o_Overflow), 64'h0);
        rst_n = 1'b1;
        wait_cycles(2);

        // Debounce: third identical scan is accepted one edge after its strobe
        ia.i_Event_Ready = 1'b1;
        push_a(3'd0, 1'b1);
        scan(1'b0, 64'h1);
        scan(1'b0, 64'h1);
        @(posedge clk); #1;
        ia.i_Data = 64'h1; ia.i_Data_Valid = 1'b1;
        @(posedge clk); #1;
        ia.i_Data_Valid = 1'b0;
        chk("deb_keys_edge_n", 64'(ia.o_Keys), 64'h00);
        @(posedge clk); #1;
        chk("deb_keys_edge_n1", 64'(ia.o_Keys), 64'h01);
        chk("deb_valid_edge_n1", 64'(ia.o_Event_Valid), 64'h0);
        @(posedge clk); #1;
        chk("deb_valid_edge_n2", 64'(ia.o_Event_Valid), 64'h1);
        wait_cycles(8);
        push_a(3'd0, 1'b0);
        repeat (3) scan(1'b0, 64'h0);
        chk("deb_release_keys", 64'(ia.o_Keys), 64'h00);

        // Glitch: the interrupting 0 restarts the count
        scan(1'b0, 64'h1);
        scan(1'b0, 64'h0);
        scan(1'b0, 64'h1);
        scan(1'b0, 64'h1);
        chk("glitch_keys", 64'(ia.o_Keys), 64'h00);
        chk("glitch_queue", 64'(qa.size()), 64'h0);
        push_a(3'd0, 1'b1);
        scan(1'b0, 64'h1);
        chk("glitch_accept_keys", 64'(ia.o_Keys), 64'h01);
        push_a(3'd0, 1'b0);
        repeat (3) scan(1'b0, 64'h0);

        // Multi-key map with upper bits set
        push_a(3'd0, 1'b1);
        push_a(3'd4, 1'b1);
        push_a(3'd5, 1'b1);
        repeat (3) scan(1'b0, 64'hFFFF_FFFF_0000_1011);
        chk("multi_keys", 64'(ia.o_Keys), 64'h31);
        chk("multi_queue_drained", 64'(qa.size()), 64'h0);

        // Reset mid-traffic with three new presses (keys 1,2,3) queued
        ia.i_Event_Ready = 1'b0;
        repeat (3) scan(1'b0, 64'h0101_1111);
        chk("pre_reset_keys", 64'(ia.o_Keys), 64'h3F);
        chk("pre_reset_head", 64'(ia.o_Event_Key), 64'h1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_keys", 64'(ia.o_Keys), 64'h00);
        chk("async_reset_valid", 64'(ia.o_Event_Valid), 64'h0);
        chk("async_reset_key", 64'(ia.o_Event_Key), 64'h0);
        chk("async_reset_press", 64'(ia.o_Event_Press), 64'h0);
        chk("async_reset_overflow", 64'(ia.o_Overflow), 64'h0);
        wait_cycles(2);
        rst_n = 1'b1;
        ia.i_Event_Ready = 1'b1;
        wait_cycles(15);
        chk("post_reset_valid", 64'(ia.o_Event_Valid), 64'h0);

        // Backpressure: 8 presses, 4 in FIFO, 4 pending
        ia.i_Event_Ready = 1'b0;
        repeat (3) scan(1'b0, 64'h1111_1111);
        chk("bp_keys", 64'(ia.o_Keys), 64'hFF);
        chk("bp_valid", 64'(ia.o_Event_Valid), 64'h1);
        chk("bp_head_key", 64'(ia.o_Event_Key), 64'h0);
        chk("bp_head_press", 64'(ia.o_Event_Press), 64'h1);
        wait_cycles(5);
        chk("bp_head_stable", 64'(ia.o_Event_Key), 64'h0);
        for (int i = 0; i < 8; i++) push_a(3'(i), 1'b1);
        ia.i_Event_Ready = 1'b1;
        wait_cycles(20);
        chk("bp_all_delivered", 64'(qa.size()), 64'h0);
        chk("bp_overflow", 64'(ia.o_Overflow), 64'h0);

        // Overflow on the single-scan debounce instance
        scan(1'b1, 64'h0101_0101);
        scan(1'b1, 64'h1101_0101);
        scan(1'b1, 64'h0101_0101);
        chk("ovf_keys", 64'(ib.o_Keys), 64'h0F);
        chk("ovf_flag", 64'(ib.o_Overflow), 64'h1);
        chk("ovf_valid", 64'(ib.o_Event_Valid), 64'h1);
        for (int i = 0; i < 4; i++) push_b(3'(i), 1'b1);
        push_b(3'd7, 1'b0);
        ib.i_Event_Ready = 1'b1;
        wait_cycles(20);
        chk("ovf_all_delivered", 64'(qb.size()), 64'h0);
        chk("ovf_flag_sticky", 64'(ib.o_Overflow), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
